wb_sram8_ctrl: RTL and testbench
================================

WB_SRAM8_CTRL -- requirements
Module: wb_sram8_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3: read_n/write_n low time per byte, in clocks; legal range 1..15.
REQ-002 SHALL have parameter TURN_CYCLES, default 1: strobe-high hold/turnaround per byte, in clocks; legal range 1..7.
REQ-003 SHALL have ports as follows; one clock; reset is synchronous and active-high:
  i_clk  in  1  system clock, all logic on rising edge
  i_reset  in  1  synchronous active-high reset
  i_wb_adr  in  32  byte address; only [22:0] used
  i_wb_sel  in  4  byte lane enables
  i_wb_we  in  1  write request
  i_wb_dat  in  32  write data
  i_wb_cyc  in  1  bus cycle
  i_wb_stb  in  1  strobe
  o_wb_dat  out  32  read data, valid with ack
  o_wb_ack  out  1  one-cycle acknowledge
  o_sram_cs_n  out  4  chip selects, one-hot low
  o_sram_read_n  out  1  read strobe
  o_sram_write_n  out  1  write strobe
  o_sram_addr  out  21  byte address within chip
  o_sram_data  out  8  write data to pad
  o_sram_data_oe  out  1  pad output enable (tristate lives in top)
  i_sram_data  in  8  read data from pad

Function
REQ-004 SHALL accept a request in IDLE when i_wb_cyc & i_wb_stb; latch adr, sel, we, dat; byte index idx = 0.
REQ-005 SHALL select chip i_wb_adr[22:21]: o_sram_cs_n = ~(4'b0001 << adr[22:21]) from SETUP through last HOLD.
REQ-006 SHALL drive o_sram_addr = {adr[20:2], idx}; lane idx maps to o_wb_dat[8*idx+7:8*idx] (little-endian).
REQ-007 SHALL sequence per byte: SETUP (1 clk, addr/cs/data valid, strobes high) -> STROBE (WAIT_CYCLES clk, one strobe low) -> HOLD (TURN_CYCLES clk, strobes high, addr/cs/data held).
REQ-008 Reads SHALL fetch all four bytes regardless of i_wb_sel; capture i_sram_data on the last STROBE clock.
REQ-009 Writes SHALL skip lanes with sel bit 0 (no SETUP/STROBE/HOLD); o_sram_data_oe high SETUP..HOLD of written bytes only.
REQ-010 After idx 3 processed, SHALL enter ACK: o_wb_ack high exactly one clock, then IDLE.
REQ-011 Read latency accept-to-ack SHALL be 4*(1+WAIT_CYCLES+TURN_CYCLES)+1 clocks (21 at defaults).
REQ-012 Write with i_wb_sel = 0 SHALL perform no SRAM cycle and ack on the next clock.
REQ-013 If i_wb_stb or i_wb_cyc falls before ACK, SRAM sequence SHALL complete; ack SHALL be suppressed.
REQ-014 o_sram_read_n and o_sram_write_n SHALL never be low simultaneously; strobes SHALL only be low while a cs_n is low.
REQ-015 STROBE counter SHALL be 4 bits, HOLD counter 3 bits; no wrap beyond parameter value.

Reset
REQ-016 On i_reset, next edge: state IDLE, cs_n 4'hF, read_n 1, write_n 1, oe 0, addr 0, o_sram_data 0, o_wb_dat 0, ack 0.
REQ-017 Reset mid-transfer SHALL abort without ack; no pending posted write survives.

Configuration
REQ-018 Macro SRAM_POSTED_WRITE_EN: when defined, write acked the clock after acceptance, SRAM write runs in background; next request not accepted (no ack) until background write completes.
REQ-019 Without SRAM_POSTED_WRITE_EN, write ack per REQ-010 after last written byte.

Structure
REQ-020 Package sram_pkg SHALL hold the state enumeration (IDLE, SETUP, STROBE, HOLD, ACK), default WAIT/TURN constants, chip-count and address-width constants.
REQ-021 One sub-module sram_cycle_timer SHALL generate STROBE/HOLD terminal counts.

Verification
REQ-022 Read adr 0x0020_0004 with chip 1 memory holding 0x11,0x22,0x33,0x44 at 4..7 -> cs_n 4'b1101, ack at clock 21, o_wb_dat 0x4433_2211.
REQ-023 Write adr 0x0060_0000, sel 4'b0101, dat 0xAABB_CCDD -> exactly two write_n pulses of 3 clocks, addr 0 data 0xDD, addr 2 data 0xBB, cs_n 4'b0111.
REQ-024 Write sel 4'b0000 -> no cs_n activity, ack one clock after accept.
REQ-025 Assert i_reset during second byte STROBE of a read -> strobes high, cs_n 4'hF next clock, no ack.
REQ-026 With SRAM_POSTED_WRITE_EN, write then immediate read -> write ack at clock 1, read accepted only after last write HOLD, read data correct.
REQ-027 Drop i_wb_stb at clock 5 of a read -> four read_n pulses still occur, o_wb_ack stays 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the Wishbone-to-8-bit SRAM controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    localparam int DEF_WAIT_CYCLES = 3;
    localparam int DEF_TURN_CYCLES = 1;
    localparam int NUM_CHIPS       = 4;
    localparam int CHIP_ADDR_W     = 21;
    localparam int WB_ADDR_USED    = 23;

    // Lowest lane at or above start whose mask bit is set; 4 means none left.
    function automatic logic [2:0] next_lane(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] lane;
        lane = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) lane = 3'(i);
        end
        return lane;
    endfunction

endpackage

// File: rtl/sram_cycle_timer.sv
// Down-counters producing the terminal counts for the STROBE and HOLD phases.
module sram_cycle_timer
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic   i_clk,
    input  logic   i_reset,
    input  state_t i_state,
    output logic   o_strobe_tc,
    output logic   o_hold_tc
);

    localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [2:0] HOLD_LOAD   = 3'(TURN_CYCLES - 1);

    logic [3:0] r_strobe_cnt;
    logic [2:0] r_hold_cnt;

    // Counters sit preloaded outside their phase and saturate at zero inside it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_strobe_cnt <= STROBE_LOAD;
            r_hold_cnt   <= HOLD_LOAD;
        end else begin
            if (i_state != STROBE) r_strobe_cnt <= STROBE_LOAD;
            else if (r_strobe_cnt != 4'd0) r_strobe_cnt <= r_strobe_cnt - 4'd1;

            if (i_state != HOLD) r_hold_cnt <= HOLD_LOAD;
            else if (r_hold_cnt != 3'd0) r_hold_cnt <= r_hold_cnt - 3'd1;
        end
    end

    assign o_strobe_tc = (i_state == STROBE) && (r_strobe_cnt == 4'd0);
    assign o_hold_tc   = (i_state == HOLD) && (r_hold_cnt == 3'd0);

endmodule

// File: rtl/wb_sram8_ctrl.sv
// Wishbone 32-bit slave driving four 8-bit asynchronous SRAMs one byte at a time.
// Optional SRAM_POSTED_WRITE_EN: writes are acked immediately and finish in the background.
//
// state  | meaning
// IDLE   | waiting for cyc & stb
// SETUP  | address, chip select and write data valid, strobes high
// STROBE | read_n or write_n low for WAIT_CYCLES clocks
// HOLD   | strobes high, address/cs/data held for TURN_CYCLES clocks
// ACK    | one-clock acknowledge (suppressed if the master abandoned the cycle)
module wb_sram8_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [31:0]            i_wb_adr,
    input  logic [3:0]             i_wb_sel,
    input  logic                   i_wb_we,
    input  logic [31:0]            i_wb_dat,
    input  logic                   i_wb_cyc,
    input  logic                   i_wb_stb,
    output logic [31:0]            o_wb_dat,
    output logic                   o_wb_ack,
    output logic [NUM_CHIPS-1:0]   o_sram_cs_n,
    output logic                   o_sram_read_n,
    output logic                   o_sram_write_n,
    output logic [CHIP_ADDR_W-1:0] o_sram_addr,
    output logic [7:0]             o_sram_data,
    output logic                   o_sram_data_oe,
    input  logic [7:0]             i_sram_data
);

    state_t      r_state, w_state_next;
    logic [18:0] r_adr_hi;
    logic [1:0]  r_chip;
    logic [3:0]  r_sel;
    logic        r_we;
    logic [31:0] r_dat;
    logic [1:0]  r_idx;
    logic        r_ack_ok;
    logic [CHIP_ADDR_W-1:0] r_sram_addr;
    logic [7:0]  r_sram_data;
    logic [31:0] r_rdata;

    logic        w_req, w_active, w_strobe_tc, w_hold_tc, w_posted, w_post_ack;
    logic [3:0]  w_mask;
    logic [2:0]  w_start, w_lane;
    logic [18:0] w_adr_src;
    logic [31:0] w_dat_src;
    logic        w_we_src;
    logic        w_unused_adr;

    assign w_unused_adr = &{1'b0, i_wb_adr[31:WB_ADDR_USED], i_wb_adr[1:0]};

`ifdef SRAM_POSTED_WRITE_EN
    logic r_posted, r_post_ack;
    assign w_posted   = r_posted;
    assign w_post_ack = r_post_ack;
`else
    assign w_posted   = 1'b0;
    assign w_post_ack = 1'b0;
`endif

    sram_cycle_timer #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .TURN_CYCLES(TURN_CYCLES)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_state     (r_state),
        .o_strobe_tc (w_strobe_tc),
        .o_hold_tc   (w_hold_tc)
    );

    assign w_req    = i_wb_cyc & i_wb_stb;
    assign w_active = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);

    // In IDLE the next lane comes straight from the bus; afterwards from the latched request.
    always_comb begin
        w_we_src  = (r_state == IDLE) ? i_wb_we : r_we;
        w_adr_src = (r_state == IDLE) ? i_wb_adr[20:2] : r_adr_hi;
        w_dat_src = (r_state == IDLE) ? i_wb_dat : r_dat;
        w_mask    = (r_state == IDLE) ? (i_wb_we ? i_wb_sel : 4'hF) : (r_we ? r_sel : 4'hF);
        w_start   = (r_state == IDLE) ? 3'd0 : ({1'b0, r_idx} + 3'd1);
        w_lane    = next_lane(w_mask, w_start);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_next = w_lane[2] ? ACK : SETUP;
            SETUP:   w_state_next = STROBE;
            STROBE:  if (w_strobe_tc) w_state_next = HOLD;
            HOLD:    if (w_hold_tc) w_state_next = w_lane[2] ? (w_posted ? IDLE : ACK) : SETUP;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_adr_hi    <= '0;
            r_chip      <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_dat       <= '0;
            r_idx       <= '0;
            r_ack_ok    <= 1'b0;
            r_sram_addr <= '0;
            r_sram_data <= '0;
            r_rdata     <= '0;
`ifdef SRAM_POSTED_WRITE_EN
            r_posted    <= 1'b0;
            r_post_ack  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_req) begin
                r_adr_hi <= i_wb_adr[20:2];
                r_chip   <= i_wb_adr[22:21];
                r_sel    <= i_wb_sel;
                r_we     <= i_wb_we;
                r_dat    <= i_wb_dat;
                r_ack_ok <= 1'b1;
`ifdef SRAM_POSTED_WRITE_EN
                r_posted   <= i_wb_we && (i_wb_sel != 4'h0);
                r_post_ack <= i_wb_we && (i_wb_sel != 4'h0);
`endif
            end else begin
`ifdef SRAM_POSTED_WRITE_EN
                r_post_ack <= 1'b0;
`endif
                if (w_active && !w_req) r_ack_ok <= 1'b0;
            end
            if (w_state_next == SETUP) begin
                r_idx       <= w_lane[1:0];
                r_sram_addr <= {w_adr_src, w_lane[1:0]};
                if (w_we_src) r_sram_data <= w_dat_src[{w_lane[1:0], 3'b000} +: 8];
            end
            if (r_state == STROBE && w_strobe_tc && !r_we)
                r_rdata[{r_idx, 3'b000} +: 8] <= i_sram_data;
        end
    end

    assign o_sram_cs_n    = w_active ? ~(4'b0001 << r_chip) : 4'hF;
    assign o_sram_read_n  = !((r_state == STROBE) && !r_we);
    assign o_sram_write_n = !((r_state == STROBE) && r_we);
    assign o_sram_data_oe = w_active && r_we;
    assign o_sram_addr    = r_sram_addr;
    assign o_sram_data    = r_sram_data;
    assign o_wb_dat       = r_rdata;
    assign o_wb_ack       = ((r_state == ACK) && r_ack_ok) || w_post_ack;

endmodule

// File: tb/tb_wb_sram8_ctrl.sv
// Bench for wb_sram8_ctrl: per-cycle expected pin timeline built from transaction rules,
// plus literal checks on latency, data and strobe counts.
module tb_wb_sram8_ctrl;

    localparam int W = 3;
    localparam int T = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, cyc, stb;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack, o_sram_read_n, o_sram_write_n, o_sram_data_oe;
    logic [3:0]  o_sram_cs_n;
    logic [20:0] o_sram_addr;
    logic [7:0]  o_sram_data, sram_rd;

    wb_sram8_ctrl #(.WAIT_CYCLES(W), .TURN_CYCLES(T)) dut (
        .i_clk(clk), .i_reset(rst), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_dat(wdat), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_dat(o_wb_dat),
        .o_wb_ack(o_wb_ack), .o_sram_cs_n(o_sram_cs_n), .o_sram_read_n(o_sram_read_n),
        .o_sram_write_n(o_sram_write_n), .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data),
        .o_sram_data_oe(o_sram_data_oe), .i_sram_data(sram_rd)
    );

    typedef struct packed {
        logic [3:0]  cs_n;
        logic        rd_n, wr_n, oe, ack;
        logic        chk_addr;
        logic [20:0] addr;
        logic        chk_data;
        logic [7:0]  data;
        logic        chk_rdat;
        logic [31:0] rdat;
    } exp_t;

    exp_t       q[$];
    logic [7:0] sram    [0:1023];
    logic [7:0] ref_mem [0:1023];
    int  n_cmp = 0, n_bad = 0;
    bit  chk_en = 0;
    int  rd_falls, wr_falls, wr_low, ack_cnt, cs_low;
    logic [3:0] last_cs;
    logic prev_rd = 1'b1, prev_wr = 1'b1;
    int  pad_i;

    function automatic int pad_idx(input logic [3:0] cs_n, input logic [20:0] a);
        int c;
        c = -1;
        for (int k = 0; k < 4; k++) if (cs_n == ~(4'b0001 << k)) c = k;
        return (c < 0) ? -1 : c * 256 + int'(a[7:0]);
    endfunction

    assign pad_i   = pad_idx(o_sram_cs_n, o_sram_addr);
    assign sram_rd = (!o_sram_read_n && pad_i >= 0) ? sram[pad_i] : 8'h00;

    function automatic exp_t idle_rec();
        exp_t e;
        e = '0;
        e.cs_n = 4'hF;
        e.rd_n = 1'b1;
        e.wr_n = 1'b1;
        return e;
    endfunction

    // Pad-side SRAM, strobe counters and the per-cycle comparison against the timeline.
    initial begin
        exp_t e;
        bit bad;
        for (int i = 0; i < 1024; i++) sram[i] = 8'h00;
        sram[256+4] = 8'h11; sram[256+5] = 8'h22; sram[256+6] = 8'h33; sram[256+7] = 8'h44;
        forever begin
            @(negedge clk);
            if (!o_sram_write_n && pad_i >= 0) sram[pad_i] = o_sram_data;
            if (prev_rd && !o_sram_read_n) rd_falls++;
            if (prev_wr && !o_sram_write_n) wr_falls++;
            if (!o_sram_write_n) wr_low++;
            if (o_wb_ack) ack_cnt++;
            if (o_sram_cs_n != 4'hF) begin cs_low++; last_cs = o_sram_cs_n; end
            prev_rd = o_sram_read_n;
            prev_wr = o_sram_write_n;
            if (chk_en) begin
                e = (q.size() > 0) ? q.pop_front() : idle_rec();
                bad = (o_sram_cs_n !== e.cs_n) || (o_sram_read_n !== e.rd_n) ||
                      (o_sram_write_n !== e.wr_n) || (o_sram_data_oe !== e.oe) ||
                      (o_wb_ack !== e.ack) || (e.chk_addr && (o_sram_addr !== e.addr)) ||
                      (e.chk_data && (o_sram_data !== e.data)) ||
                      (e.chk_rdat && (o_wb_dat !== e.rdat));
                n_cmp++;
                if (bad) begin
                    n_bad++;
                    $display("FAIL pins@%0t got/expected: cs_n %b/%b rd_n %b/%b wr_n %b/%b oe %b/%b ack %b/%b addr %h/%h data %h/%h wb_dat %h/%h",
                             $time, o_sram_cs_n, e.cs_n, o_sram_read_n, e.rd_n, o_sram_write_n, e.wr_n,
                             o_sram_data_oe, e.oe, o_wb_ack, e.ack, o_sram_addr, e.addr,
                             o_sram_data, e.data, o_wb_dat, e.rdat);
                end
            end
        end
    end

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected timeline for one transaction accepted at the next rising edge.
    task automatic push_xact(input logic [31:0] a, input logic [3:0] s, input logic w,
                             input logic [31:0] d, input bit want_ack);
        exp_t e;
        int base;
        bit posted, first;
        posted = 0;
`ifdef SRAM_POSTED_WRITE_EN
        posted = w && (s != 4'h0);
`endif
        base  = int'(a[22:21]) * 256 + int'(a[7:2]) * 4;
        first = 1;
        for (int lane = 0; lane < 4; lane++) begin
            if (w && !s[lane]) continue;
            e = idle_rec();
            e.cs_n = ~(4'b0001 << a[22:21]);
            e.oe = w;
            e.chk_addr = 1'b1;
            e.addr = {a[20:2], 2'(lane)};
            e.chk_data = w;
            e.data = d[8*lane +: 8];
            e.ack = posted && first;
            q.push_back(e);
            first = 0;
            e.ack = 1'b0;
            e.rd_n = w;
            e.wr_n = !w;
            for (int c = 0; c < W; c++) q.push_back(e);
            e.rd_n = 1'b1;
            e.wr_n = 1'b1;
            for (int c = 0; c < T; c++) q.push_back(e);
            if (w) ref_mem[base + lane] = d[8*lane +: 8];
        end
        if (!posted) begin
            e = idle_rec();
            e.ack = want_ack;
            if (!w && want_ack) begin
                e.chk_rdat = 1'b1;
                e.rdat = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
            end
            q.push_back(e);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] s, input logic w,
                         input logic [31:0] d, input bit want_ack, input bit now);
        int guard;
        guard = 0;
        if (!now) begin
            while (q.size() != 0 && guard < 300) begin @(negedge clk); #1; guard++; end
            if (guard >= 300) check_val("issue_wait_timeout", 32'(q.size()), 32'd0);
            @(negedge clk); #1;
        end
        if (q.size() > 0) q.push_back(idle_rec());
        adr = a; sel = s; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
        push_xact(a, s, w, d, want_ack);
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (!o_wb_ack && lat < 300);
        if (lat >= 300) check_val("ack_timeout", 32'(o_wb_ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 300) begin @(negedge clk); #1; guard++; end
        if (guard >= 300) check_val("drain_timeout", 32'(q.size()), 32'd0);
        repeat (2) begin @(negedge clk); #1; end
    endtask

    task automatic clr();
        rd_falls = 0; wr_falls = 0; wr_low = 0; ack_cnt = 0; cs_low = 0; last_cs = 4'hF;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lat_exp;
        rst = 1'b1; adr = '0; sel = '0; we = 1'b0; wdat = '0; cyc = 1'b0; stb = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        ref_mem[256+4] = 8'h11; ref_mem[256+5] = 8'h22; ref_mem[256+6] = 8'h33; ref_mem[256+7] = 8'h44;
        clr();
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_cs_n", 32'(o_sram_cs_n), 32'hF);
        check_val("reset_read_n", 32'(o_sram_read_n), 32'd1);
        check_val("reset_write_n", 32'(o_sram_write_n), 32'd1);
        check_val("reset_oe", 32'(o_sram_data_oe), 32'd0);
        check_val("reset_addr", 32'(o_sram_addr), 32'd0);
        check_val("reset_sram_data", 32'(o_sram_data), 32'd0);
        check_val("reset_wb_dat", o_wb_dat, 32'd0);
        check_val("reset_ack", 32'(o_wb_ack), 32'd0);
        rst = 1'b0;
        chk_en = 1;

        // Read of chip 1, bytes 4..7.
        clr();
        issue(32'h0020_0004, 4'hF, 1'b0, 32'h0, 1, 0);
        wait_ack(lat);
        check_val("read_latency", 32'(lat), 32'd21);
        check_val("read_data", o_wb_dat, 32'h4433_2211);
        check_val("read_pulses", 32'(rd_falls), 32'd4);
        check_val("read_cs_n", 32'(last_cs), 32'b1101);

        // Sparse write to chip 3: lanes 0 and 2 only.
        drain(); clr();
        issue(32'h0060_0000, 4'b0101, 1'b1, 32'hAABB_CCDD, 1, 0);
        wait_ack(lat);
`ifdef SRAM_POSTED_WRITE_EN
        lat_exp = 1;
`else
        lat_exp = 2 * (1 + W + T) + 1;
`endif
        check_val("write_latency", 32'(lat), 32'(lat_exp));
        drain();
        check_val("write_pulses", 32'(wr_falls), 32'd2);
        check_val("write_low_clocks", 32'(wr_low), 32'd6);
        check_val("write_byte0", 32'(sram[768+0]), 32'hDD);
        check_val("write_byte1_untouched", 32'(sram[768+1]), 32'h00);
        check_val("write_byte2", 32'(sram[768+2]), 32'hBB);
        check_val("write_cs_n", 32'(last_cs), 32'b0111);

        // Write with no lanes selected.
        clr();
        issue(32'h0040_0010, 4'b0000, 1'b1, 32'h1234_5678, 1, 0);
        wait_ack(lat);
        check_val("sel0_latency", 32'(lat), 32'd1);
        drain();
        check_val("sel0_cs_activity", 32'(cs_low), 32'd0);

        // Read back the sparse write.
        issue(32'h0060_0000, 4'b0001, 1'b0, 32'h0, 1, 0);
        wait_ack(lat);
        check_val("readback_sparse", o_wb_dat, 32'h00BB_00DD);

        // Full word write and read back on chip 0.
        drain();
        issue(32'h0000_0008, 4'hF, 1'b1, 32'hCAFE_F00D, 1, 0);
        wait_ack(lat);
        issue(32'h0000_0008, 4'hF, 1'b0, 32'h0, 1, 0);
        wait_ack(lat);
        check_val("readback_full", o_wb_dat, 32'hCAFE_F00D);

        // Top lane only, chip 2.
        drain(); clr();
        issue(32'h0040_000C, 4'b1000, 1'b1, 32'h5A00_0000, 1, 0);
        wait_ack(lat);
        drain();
        check_val("lane3_pulses", 32'(wr_falls), 32'd1);
        check_val("lane3_byte", 32'(sram[512+15]), 32'h5A);

        // Master abandons a read at clock 5: sequence completes, no ack.
        clr();
        issue(32'h0020_0004, 4'hF, 1'b0, 32'h0, 0, 0);
        repeat (5) begin @(negedge clk); #1; end
        cyc = 1'b0; stb = 1'b0;
        drain();
        check_val("abort_read_pulses", 32'(rd_falls), 32'd4);
        check_val("abort_ack_count", 32'(ack_cnt), 32'd0);

        // Reset during the second byte's STROBE.
        clr();
        issue(32'h0020_0004, 4'hF, 1'b0, 32'h0, 1, 0);
        repeat (7) begin @(negedge clk); #1; end
        check_val("mid_read_strobe", 32'(o_sram_read_n), 32'd0);
        check_val("mid_read_addr", 32'(o_sram_addr), 32'd5);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        q.delete();
        @(negedge clk); #1;
        check_val("rst_mid_cs_n", 32'(o_sram_cs_n), 32'hF);
        check_val("rst_mid_read_n", 32'(o_sram_read_n), 32'd1);
        check_val("rst_mid_wb_dat", o_wb_dat, 32'd0);
        rst = 1'b0;
        repeat (25) begin @(negedge clk); #1; end
        check_val("rst_mid_no_ack", 32'(ack_cnt), 32'd0);

`ifdef SRAM_POSTED_WRITE_EN
        // Posted write followed immediately by a read of the same word.
        issue(32'h0020_0008, 4'hF, 1'b1, 32'h8765_4321, 1, 0);
        wait_ack(lat);
        check_val("posted_write_latency", 32'(lat), 32'd1);
        issue(32'h0020_0008, 4'hF, 1'b0, 32'h0, 1, 1);
        wait_ack(lat);
        check_val("posted_read_latency", 32'(lat), 32'd41);
        check_val("posted_read_data", o_wb_dat, 32'h8765_4321);
`endif

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
